// File: rtl/serial_sub_8.sv
// Bit-serial 8-bit subtractor: D = A - B - bin, one bit per clock, LSB first,
// with a single full-subtractor cell, a registered borrow and a start/busy/done handshake.
module serial_sub_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       bin,
  output logic [7:0] D,
  output logic       bout,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  r_sr_q, r_sr_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic a_bit_c, b_bit_c, diff_bit_c, br_next_c, accept_c;

  // Full-subtractor cell plus next-state logic.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    accept_c = 1'b0;

    a_bit_c    = a_sr_q[0];
    b_bit_c    = b_sr_q[0];
    diff_bit_c = a_bit_c ^ b_bit_c ^ br_q;
    br_next_c  = (~a_bit_c & b_bit_c) | (~(a_bit_c ^ b_bit_c) & br_q);

    case (state_q)
      S_IDLE: begin
        if (start) accept_c = 1'b1;
      end
      S_RUN: begin
        a_sr_d = {1'b0, a_sr_q[W-1:1]};
        b_sr_d = {1'b0, b_sr_q[W-1:1]};
        r_sr_d = {diff_bit_c, r_sr_q[W-1:1]};
        br_d   = br_next_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          d_d     = r_sr_d;
          bout_d  = br_next_c;
          // br_q here is the borrow into bit 7
          ovf_d   = br_q ^ br_next_c;
        end
      end
      S_DONE: begin
        // The DONE->IDLE edge doubles as the next accept edge, giving a 9-cycle cadence.
        state_d = S_IDLE;
        if (start) accept_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_c) begin
      state_d = S_RUN;
      a_sr_d  = A;
      b_sr_d  = B;
      br_d    = bin;
      cnt_d   = '0;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench for serial_sub_8: directed corner cases, handshake and
// reset scenarios, and random operands against an arithmetic reference model.
module tb_serial_sub_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       bin;
  logic [7:0] D;
  logic       bout, ovf, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .bin  (bin),
    .D    (D),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Returns {ovf, bout, D} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int u, s;
    logic [9:0] r;
    u = int'(a) - int'(b) - int'(bi);
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    r[7:0] = 8'(u);
    r[8]   = (u < 0);
    r[9]   = (s < -128) || (s > 127);
    return r;
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit poke);
    logic [9:0] e;
    logic [7:0] d_prev;
    int k;
    bit seen;
    e = model(a, b, bi);
    d_prev = D;
    @(negedge clk);
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
    check("busy_rise", busy, 1);
    check("done_low_run", done, 0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (poke && k == 3) begin
        start = 1'b1; A = ~a; B = a; bin = ~bi;
      end
      if (poke && k == 4) start = 1'b0;
      if (done) seen = 1'b1;
      else if (k == 4) check("d_hold_run", D, d_prev);
    end
    check("done_latency", k, 8);
    check("busy_in_done", busy, 0);
    check("D", D, e[7:0]);
    check("bout", bout, e[8]);
    check("ovf", ovf, e[9]);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    logic [9:0] e1, e2;
    int k;
    bit seen;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    #12;
    check("rst_D", D, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h5A, 8'h23, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    do_op(8'h10, 8'h10, 1'b1, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0);
    do_op(8'h3C, 8'h81, 1'b0, 1'b1);

    // start held high: second accept lands on the DONE->IDLE edge
    e1 = model(8'h12, 8'h34, 1'b0);
    e2 = model(8'hC3, 8'h5A, 1'b1);
    @(negedge clk);
    A = 8'h12; B = 8'h34; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'hC3; B = 8'h5A; bin = 1'b1;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      if (done) seen = 1'b1;
    end
    check("hold_lat1", k, 8);
    check("hold_D1", D, e1[7:0]);
    @(negedge clk);
    start = 1'b0;
    check("hold_reaccept", busy, 1);
    check("hold_done_gone", done, 0);
    check("hold_D_held", D, e1[7:0]);
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      if (done) seen = 1'b1;
      else if (k == 5) check("hold_D_mid", D, e1[7:0]);
    end
    check("hold_lat2", k, 8);
    check("hold_D2", D, e2[7:0]);
    check("hold_bout2", bout, e2[8]);
    check("hold_ovf2", ovf, e2[9]);
    @(negedge clk);

    for (int i = 0; i < 30; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Asynchronous reset mid-operation
    do_op(8'h5A, 8'h23, 1'b0, 1'b0);
    @(negedge clk);
    A = 8'hA5; B = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_D", D, 0);
    check("arst_bout", bout, 0);
    check("arst_ovf", ovf, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("arst_no_done", 32'(seen), 0);
    check("arst_D_kept", D, 0);
    do_op(8'h05, 8'h03, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
